// File: rtl/sd_rx_block_packer.sv
// Packs SD receive bytes into 64-bit words and fills ping-pong 64-word banks of the block RAM.
// Latency: one registered write cycle after the 8th byte of a group is accepted.
// Backpressure: none on bytes in FILL; a start with no free bank is refused and flagged on ovr_err.
module sd_rx_block_packer #(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  byte_in,
    input  logic        byte_vld,
    input  logic [1:0]  bank_release,
    output logic [7:0]  bram_addr,
    output logic [63:0] bram_datain,
    output logic        bram_wr,
    output logic        blk_done,
    output logic        blk_bank,
    output logic [1:0]  bank_full,
    output logic        busy,
    output logic        ovr_err
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_FILL = 1'b1;

    logic [0:0]  state;
    logic        wb;
    logic [2:0]  byte_cnt;
    logic [5:0]  word_cnt;
    logic [63:0] asm_q;
    logic [63:0] asm_next;
    logic [1:0]  full_rel;

    // Releases apply before the free-check and before a same-cycle set, so the set wins.
    always_comb begin
        asm_next = BIG_ENDIAN ? {asm_q[55:0], byte_in} : {byte_in, asm_q[63:8]};
        full_rel = bank_full & ~bank_release;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            wb          <= 1'b0;
            byte_cnt    <= 3'd0;
            word_cnt    <= 6'd0;
            asm_q       <= 64'd0;
            bram_addr   <= 8'd0;
            bram_datain <= 64'd0;
            bram_wr     <= 1'b0;
            blk_done    <= 1'b0;
            blk_bank    <= 1'b0;
            bank_full   <= 2'b00;
            busy        <= 1'b0;
            ovr_err     <= 1'b0;
        end else begin
            bram_wr   <= 1'b0;
            blk_done  <= 1'b0;
            ovr_err   <= 1'b0;
            bank_full <= full_rel;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (!full_rel[wb]) begin
                            state    <= S_FILL;
                            busy     <= 1'b1;
                            byte_cnt <= 3'd0;
                            word_cnt <= 6'd0;
                        end else begin
                            ovr_err <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (abort) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        byte_cnt <= 3'd0;
                        word_cnt <= 6'd0;
                    end else if (byte_vld) begin
                        asm_q    <= asm_next;
                        byte_cnt <= byte_cnt + 3'd1;
                        if (byte_cnt == 3'd7) begin
                            bram_wr     <= 1'b1;
                            bram_addr   <= {1'b0, wb, word_cnt};
                            bram_datain <= asm_next;
                            word_cnt    <= word_cnt + 6'd1;
                            if (word_cnt == 6'd63) begin
                                blk_done  <= 1'b1;
                                blk_bank  <= wb;
                                bank_full <= full_rel | (wb ? 2'b10 : 2'b01);
                                wb        <= ~wb;
                                state     <= S_IDLE;
                                busy      <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
